// File: rtl/core_id_pipe_if.sv
// core_id_pipe_if: IF/ID-to-EX decode stage bus; upstream handshake, regfile read, hazard inputs and decoded outputs.
interface core_id_pipe_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       inst_in;
    logic [ADDR_W-1:0] inst_addr_in;
    logic [4:0]        read_reg1_addr_out;
    logic [4:0]        read_reg2_addr_out;
    logic [XLEN-1:0]   read_reg1_data_in;
    logic [XLEN-1:0]   read_reg2_data_in;
    logic              ex_load_in;
    logic [4:0]        ex_rd_in;
    logic              flush_in;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] inst_addr_out;
    logic              reg_we_out;
    logic [4:0]        reg_write_addr_out;
    logic [XLEN-1:0]   opnum1_out;
    logic [XLEN-1:0]   opnum2_out;
    logic [3:0]        func_out;
    logic              eval_en;
    logic              illegal_out;
    logic [CNT_W-1:0]  stall_cnt_out;

    modport slave (
        input  in_valid, inst_in, inst_addr_in, read_reg1_data_in, read_reg2_data_in,
               ex_load_in, ex_rd_in, flush_in, out_ready,
        output in_ready, read_reg1_addr_out, read_reg2_addr_out, out_valid, inst_addr_out,
               reg_we_out, reg_write_addr_out, opnum1_out, opnum2_out, func_out, eval_en,
               illegal_out, stall_cnt_out
    );

    modport master (
        output in_valid, inst_in, inst_addr_in, read_reg1_data_in, read_reg2_data_in,
               ex_load_in, ex_rd_in, flush_in, out_ready,
        input  in_ready, read_reg1_addr_out, read_reg2_addr_out, out_valid, inst_addr_out,
               reg_we_out, reg_write_addr_out, opnum1_out, opnum2_out, func_out, eval_en,
               illegal_out, stall_cnt_out
    );
endinterface

// File: rtl/core_id_pipe.sv
// core_id_pipe: registered RV32I ALU-subset decode stage with load-use stall detection,
// valid/ready output register, flush and a saturating stall-cycle counter.
module core_id_pipe #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input logic clk,
    input logic rst,
    core_id_pipe_if.slave bus
);
    localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LUI = 7'b0110111, AUIPC = 7'b0010111;

    logic [31:0] inst;
    logic [6:0]  opc;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        alt;
    assign inst = bus.inst_in;
    assign opc  = inst[6:0];
    assign rs1  = inst[19:15];
    assign rs2  = inst[24:20];
    assign rd   = inst[11:7];
    assign f3   = inst[14:12];
    assign alt  = inst[30];

    function automatic logic [3:0] alu_fn(input logic [2:0] f, input logic a);
        case (f)
            3'd0:    alu_fn = a ? 4'd1 : 4'd0;
            3'd1:    alu_fn = 4'd2;
            3'd2:    alu_fn = 4'd3;
            3'd3:    alu_fn = 4'd4;
            3'd4:    alu_fn = 4'd5;
            3'd5:    alu_fn = a ? 4'd7 : 4'd6;
            3'd6:    alu_fn = 4'd8;
            default: alu_fn = 4'd9;
        endcase
    endfunction

    logic            use1, use2, we, en, ill;
    logic [XLEN-1:0] op1, op2;
    logic [3:0]      fn;

    always_comb begin
        use1 = 1'b0;
        use2 = 1'b0;
        we   = 1'b0;
        en   = 1'b0;
        ill  = 1'b0;
        op1  = '0;
        op2  = '0;
        fn   = 4'd0;
        case (opc)
            OP: begin
                use1 = 1'b1;
                use2 = 1'b1;
                we   = 1'b1;
                en   = 1'b1;
                op1  = bus.read_reg1_data_in;
                op2  = bus.read_reg2_data_in;
                fn   = alu_fn(f3, alt);
            end
            OPI: begin
                use1 = 1'b1;
                we   = 1'b1;
                en   = 1'b1;
                op1  = bus.read_reg1_data_in;
                op2  = (f3 == 3'b001 || f3 == 3'b101) ? XLEN'(inst[24:20])
                                                      : {{(XLEN-12){inst[31]}}, inst[31:20]};
                // Only the shift-right slot has an alternate form; bit 30 of an ADDI immediate is data.
                fn   = alu_fn(f3, alt & (f3 == 3'b101));
            end
            LUI: begin
                we  = 1'b1;
                en  = 1'b1;
                op2 = XLEN'({inst[31:12], 12'b0});
            end
            AUIPC: begin
                we  = 1'b1;
                en  = 1'b1;
                op1 = XLEN'(bus.inst_addr_in);
                op2 = XLEN'({inst[31:12], 12'b0});
            end
            default: ill = 1'b1;
        endcase
    end

    logic hazard, accept;
    logic valid_q, valid_d, we_q, we_d, en_q, en_d, ill_q, ill_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   op1_q, op1_d, op2_q, op2_d;
    logic [3:0]        fn_q, fn_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign hazard = bus.in_valid & bus.ex_load_in & (bus.ex_rd_in != 5'd0) &
                    ((use1 & (rs1 == bus.ex_rd_in)) | (use2 & (rs2 == bus.ex_rd_in)));
    assign bus.in_ready = (!valid_q | bus.out_ready) & !hazard & !bus.flush_in;
    assign accept = bus.in_valid & bus.in_ready;
    assign bus.read_reg1_addr_out = use1 ? rs1 : 5'd0;
    assign bus.read_reg2_addr_out = use2 ? rs2 : 5'd0;

    always_comb begin
        valid_d = bus.flush_in ? 1'b0 : accept ? 1'b1 : bus.out_ready ? 1'b0 : valid_q;
        pc_d    = accept ? bus.inst_addr_in : pc_q;
        we_d    = accept ? we : we_q;
        rd_d    = accept ? rd : rd_q;
        op1_d   = accept ? op1 : op1_q;
        op2_d   = accept ? op2 : op2_q;
        fn_d    = accept ? fn : fn_q;
        en_d    = accept ? en : en_q;
        ill_d   = accept ? ill : ill_q;
        cnt_d   = (hazard && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            we_q    <= 1'b0;
            rd_q    <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            fn_q    <= '0;
            en_q    <= 1'b0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            fn_q    <= fn_d;
            en_q    <= en_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.out_valid          = valid_q;
    assign bus.inst_addr_out      = pc_q;
    assign bus.reg_we_out         = we_q;
    assign bus.reg_write_addr_out = rd_q;
    assign bus.opnum1_out         = op1_q;
    assign bus.opnum2_out         = op2_q;
    assign bus.func_out           = fn_q;
    assign bus.eval_en            = en_q;
    assign bus.illegal_out        = ill_q;
    assign bus.stall_cnt_out      = cnt_q;
endmodule

// File: tb/tb_core_id_pipe.sv
// tb_core_id_pipe: randomized scoreboard bench for core_id_pipe against a behavioural RV32I decode model.
module tb_core_id_pipe;
    localparam int XLEN = 32, ADDR_W = 32, CNT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    core_id_pipe_if #(.XLEN(XLEN), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus();
    core_id_pipe #(.XLEN(XLEN), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] rf [32];
    assign bus.read_reg1_data_in = rf[bus.read_reg1_addr_out];
    assign bus.read_reg2_data_in = rf[bus.read_reg2_addr_out];

    typedef struct {
        logic [31:0] pc, op1, op2;
        logic        we, en, ill;
        logic [4:0]  rd;
        logic [3:0]  fn;
    } exp_t;

    exp_t        q[$];
    int          errors = 0, checks = 0;
    bit          m_valid = 1'b0;
    int unsigned m_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit uses_rs1(input logic [31:0] i);
        return i[6:0] == 7'h33 || i[6:0] == 7'h13;
    endfunction

    function automatic bit uses_rs2(input logic [31:0] i);
        return i[6:0] == 7'h33;
    endfunction

    // Reference decode: ALU code named by funct3 slot, with the two alternate encodings patched in.
    function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
        exp_t       e;
        logic [3:0] base [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        int         f3 = int'(i[14:12]);
        int         imm = int'(i[31:20]);
        e = '{pc: pc, op1: 0, op2: 0, we: 0, en: 0, ill: 0, rd: i[11:7], fn: 0};
        if (imm > 2047) imm -= 4096;
        case (i[6:0])
            7'h33: begin
                e.we = 1; e.en = 1;
                e.op1 = rf[i[19:15]];
                e.op2 = rf[i[24:20]];
                e.fn = base[f3];
                if (i[30] && f3 == 0) e.fn = 4'd1;
                if (i[30] && f3 == 5) e.fn = 4'd7;
            end
            7'h13: begin
                e.we = 1; e.en = 1;
                e.op1 = rf[i[19:15]];
                e.op2 = (f3 == 1 || f3 == 5) ? 32'(i[24:20]) : 32'(imm);
                e.fn = base[f3];
                if (i[30] && f3 == 5) e.fn = 4'd7;
            end
            7'h37: begin
                e.we = 1; e.en = 1;
                e.op2 = i & 32'hFFFF_F000;
            end
            7'h17: begin
                e.we = 1; e.en = 1;
                e.op1 = pc;
                e.op2 = i & 32'hFFFF_F000;
            end
            default: e.ill = 1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0]  bad [8] = '{7'h7F, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h73, 7'h0F};
        int          k = $urandom_range(0, 9);
        logic [2:0]  f3 = 3'($urandom);
        logic [4:0]  rd = 5'($urandom);
        logic [4:0]  rs1 = 5'($urandom_range(0, 7));
        logic [4:0]  rs2 = 5'($urandom_range(0, 7));
        logic [6:0]  f7;
        logic [11:0] imm = 12'($urandom);
        if (k < 4) begin
            f7 = ((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            return {f7, rs2, rs1, f3, rd, 7'h33};
        end
        if (k < 7) begin
            if (f3 == 1) imm[11:5] = 7'h00;
            if (f3 == 5) imm[11:5] = $urandom_range(0, 1) == 1 ? 7'h20 : 7'h00;
            return {imm, rs1, f3, rd, 7'h13};
        end
        if (k == 7) return {20'($urandom), rd, 7'h37};
        if (k == 8) return {20'($urandom), rd, 7'h17};
        return {25'($urandom), bad[$urandom_range(0, 7)]};
    endfunction

    // One cycle: drive at posedge+1, check combinational outputs and update the model at negedge+1.
    task automatic step(input bit iv, input logic [31:0] inst, input logic [31:0] pc, input bit ord,
                        input bit ld, input logic [4:0] exrd, input bit fl);
        bit u1, u2, haz, rdy, acc;
        bus.in_valid = iv; bus.inst_in = inst; bus.inst_addr_in = pc; bus.out_ready = ord;
        bus.ex_load_in = ld; bus.ex_rd_in = exrd; bus.flush_in = fl;
        @(negedge clk);
        #1;
        u1 = uses_rs1(inst);
        u2 = uses_rs2(inst);
        chk("out_valid", bus.out_valid, m_valid);
        chk("stall_cnt", bus.stall_cnt_out, m_cnt);
        chk("rd1_addr", bus.read_reg1_addr_out, u1 ? inst[19:15] : 5'd0);
        chk("rd2_addr", bus.read_reg2_addr_out, u2 ? inst[24:20] : 5'd0);
        haz = iv && ld && exrd != 0 && ((u1 && inst[19:15] == exrd) || (u2 && inst[24:20] == exrd));
        rdy = (!m_valid || ord) && !haz && !fl;
        chk("in_ready", bus.in_ready, rdy);
        acc = iv && rdy;
        if (acc) q.push_back(ref_decode(inst, pc));
        if (fl && m_valid && !ord && q.size() > 0) void'(q.pop_front());
        m_valid = fl ? 1'b0 : acc ? 1'b1 : ord ? 1'b0 : m_valid;
        if (haz && m_cnt < 65535) m_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_we", bus.reg_we_out, 0);
        chk("rst_eval_en", bus.eval_en, 0);
        chk("rst_illegal", bus.illegal_out, 0);
        chk("rst_func", bus.func_out, 0);
        chk("rst_pc", bus.inst_addr_out, 0);
        chk("rst_rd", bus.reg_write_addr_out, 0);
        chk("rst_op1", bus.opnum1_out, 0);
        chk("rst_op2", bus.opnum2_out, 0);
        chk("rst_stall_cnt", bus.stall_cnt_out, 0);
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b0;
        #1;
        check_zero();
        q.delete();
        m_valid = 1'b0;
        m_cnt = 0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst && bus.out_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got out_valid=1 at pc %0h expected no output", bus.inst_addr_out);
            end else begin
                e = q[0];
                chk("pc", bus.inst_addr_out, e.pc);
                chk("op1", bus.opnum1_out, e.op1);
                chk("op2", bus.opnum2_out, e.op2);
                chk("func", bus.func_out, e.fn);
                chk("we", bus.reg_we_out, e.we);
                chk("eval_en", bus.eval_en, e.en);
                chk("illegal", bus.illegal_out, e.ill);
                if (e.we) chk("rd", bus.reg_write_addr_out, e.rd);
                if (bus.out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : $urandom;
        rf[1] = 32'd9;
        rf[2] = 32'd4;
        bus.in_valid = 0; bus.inst_in = 0; bus.inst_addr_in = 0; bus.out_ready = 0;
        bus.ex_load_in = 0; bus.ex_rd_in = 0; bus.flush_in = 0;
        #2 rst = 1'b0;
        #10 check_zero();
        @(posedge clk);
        #1 rst = 1'b1;

        step(1, 32'h0050_0093, 32'h100, 1, 0, 0, 0);
        step(1, 32'h4020_81B3, 32'h104, 1, 0, 0, 0);
        step(1, 32'h4030_D313, 32'h108, 1, 0, 0, 0);
        step(1, 32'h1234_52B7, 32'h10C, 1, 0, 0, 0);
        step(1, 32'h0000_0297, 32'h200, 1, 0, 0, 0);
        step(0, 32'h0, 32'h0, 1, 0, 0, 0);

        step(1, 32'h0020_81B3, 32'h110, 1, 1, 5'd2, 0);
        step(1, 32'h0020_81B3, 32'h110, 1, 1, 5'd2, 0);
        step(1, 32'h0020_81B3, 32'h110, 1, 0, 5'd0, 0);
        step(1, 32'h0020_81B3, 32'h114, 1, 1, 5'd0, 0);
        step(0, 32'h0, 32'h0, 1, 0, 0, 0);

        step(1, 32'h0050_0093, 32'h120, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 32'h4020_81B3, 32'h124, 0, 0, 0, 0);
        step(1, 32'h4020_81B3, 32'h124, 0, 0, 0, 1);
        step(0, 32'h0, 32'h0, 1, 0, 0, 0);

        step(1, 32'h0000_007F, 32'h130, 1, 0, 0, 0);
        step(0, 32'h0, 32'h0, 1, 0, 0, 0);

        step(1, 32'h0050_0093, 32'h140, 0, 0, 0, 0);
        step(0, 32'h0, 32'h0, 0, 0, 0, 0);
        async_reset();

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) async_reset();
            step($urandom_range(0, 3) != 0, rand_inst(), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
                 $urandom_range(0, 15) == 0);
        end

        step(0, 32'h0, 32'h0, 1, 0, 0, 0);
        step(0, 32'h0, 32'h0, 1, 0, 0, 0);
        chk("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/core_id_pipe.md
# core_id_pipe

Registered, handshaked RV32I decode stage that replaces the purely combinational decoder between `core_if_id` and `core_ex`. It decodes the full RV32I integer ALU subset (OP, OP-IMM, LUI, AUIPC), selects ALU operands and function, flags illegal opcodes, detects load-use hazards against the EX stage, and holds its result in a one-entry pipeline register with valid/ready flow control and flush. A saturating counter reports hazard stall cycles for performance analysis.

## Interface
Parameters:
- `XLEN`, 32, data and operand width.
- `ADDR_W`, 32, instruction address width.
- `CNT_W`, 16, stall counter width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  IF/ID holds a valid instruction.
- `in_ready`  out  1  stage accepts the instruction this cycle.
- `inst_in`  in  32  instruction word.
- `inst_addr_in`  in  ADDR_W  instruction address (PC).
- `read_reg1_addr_out`  out  5  register file read address 1; combinational from `inst_in`.
- `read_reg2_addr_out`  out  5  register file read address 2; combinational from `inst_in`.
- `read_reg1_data_in`  in  XLEN  register file read data 1, same cycle.
- `read_reg2_data_in`  in  XLEN  register file read data 2, same cycle.
- `ex_load_in`  in  1  instruction currently in EX is a load.
- `ex_rd_in`  in  5  destination register of the EX instruction.
- `flush_in`  in  1  kill the stage contents (branch redirect).
- `out_valid`  out  1  output register holds a valid decoded instruction.
- `out_ready`  in  1  EX consumes the output this cycle.
- `inst_addr_out`  out  ADDR_W  registered PC.
- `reg_we_out`  out  1  registered rd write enable.
- `reg_write_addr_out`  out  5  registered rd.
- `opnum1_out`, `opnum2_out`  out  XLEN  registered ALU operands.
- `func_out`  out  4  registered ALU function.
- `eval_en`  out  1  registered ALU enable.
- `illegal_out`  out  1  registered illegal-instruction flag.
- `stall_cnt_out`  out  CNT_W  saturating load-use stall cycle count.

## Operation
- Fields: rs1=[19:15], rs2=[24:20], rd=[11:7], f3=[14:12], f7=[31:25]; immI = sign-extended [31:20]; immU = {[31:12], 12'b0}.
- ALU codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9.
- OP (0110011): op1=rs1 data, op2=rs2 data; f3 selects code; f7=0100000 selects SUB (f3=000) or SRA (f3=101); we=1, eval_en=1; uses rs1, rs2.
- OP-IMM (0010011): op1=rs1 data, op2=immI; f3=001/101 use op2={27'b0, [24:20]}, f3=101 with [30]=1 gives SRA; no SUBI; uses rs1 only.
- LUI (0110111): op1=0, op2=immU, ADD. AUIPC (0010111): op1=PC zero-extended, op2=immU, ADD. Neither uses rs1 or rs2.
- Any other opcode: illegal=1, we=0, eval_en=0, op1=op2=0, func=ADD; still passes through the handshake so the exception path sees the PC.
- Read addresses are rs1 and rs2 when used, otherwise 0.
- hazard = in_valid & ex_load_in & (ex_rd_in≠0) & ((uses_rs1 & rs1==ex_rd_in) | (uses_rs2 & rs2==ex_rd_in)).
- in_ready = (!out_valid | out_ready) & !hazard & !flush_in.
- Register load: when in_valid & in_ready, capture all decoded outputs and set out_valid=1. Otherwise, when out_ready, clear out_valid (a bubble on hazard). Otherwise hold all outputs.
- flush_in has priority: out_valid←0 next edge, input not accepted, data registers may hold stale values.
- Stall counter increments once per cycle while hazard=1, saturates at 2^CNT_W−1, and is never cleared except by reset.

## Timing
- Reset (rst=0, async): out_valid=0, reg_we_out=0, eval_en=0, illegal_out=0, func_out=0, all data/address outputs 0, stall_cnt_out=0.
- Latency 1 cycle from accept to out_valid; throughput 1 per cycle with out_ready held high.
- in_ready is combinational from out_valid, out_ready, hazard, and flush_in. No combinational path from out_ready to any registered output.
- Backpressure: with out_valid=1 and out_ready=0, outputs stay stable and in_ready=0.
- Hazard with out_ready=1: the current output drains and out_valid=0 next cycle (one bubble). The instruction is accepted once ex_load_in drops.
- Flush and accept in the same cycle: flush wins, nothing is captured.
- Reset asserted mid-stall or mid-backpressure: all state returns to reset values immediately.

## Test plan
- Reset, then addi x1,x0,5 (0x00500093), PC 0x100, out_ready=1 → next cycle out_valid=1, op1=rs1 data, op2=5, func=0, rd=1, we=1.
- sub x3,x1,x2 (0x402081B3), reg data 9 and 4 → func=1, op1=9, op2=4, rd=3. Then srai x6,x1,3 (0x4030D313) → func=7, op2=3.
- lui x5,0x12345 (0x123452B7) → op1=0, op2=0x12345000, func=0. Then auipc with PC 0x200 → op1=0x200.
- add x3,x1,x2 (0x002081B3) with ex_load_in=1, ex_rd_in=2 held 2 cycles → in_ready=0 for 2 cycles, one bubble, stall_cnt_out=2. With ex_rd_in=0 → no stall.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 → outputs stable, in_ready=0. Flush during hold → out_valid=0 next cycle.
- Opcode 0x0000007F → illegal_out=1, we=0, eval_en=0. Async reset asserted mid-transfer → all outputs 0 without waiting for a clock edge.
